// File: rtl/sum_uart_tx.sv
// Adds two 4-bit latch values and sends the sum as one UART byte.
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
module sum_uart_tx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] q_a,
  input  logic [3:0] q_b,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic          tx_n, busy_n, done_n;
  logic          bit_end;
  logic [4:0]    sum;

  assign sum     = {1'b0, q_a} + {1'b0, q_b};
  assign bit_end = (cnt == LAST);

`ifdef UART_TX_PARITY_EN
  logic par, par_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) par <= 1'b0;
    else          par <= par_n;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      tx    <= tx_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    tx_n    = tx;
    busy_n  = busy;
    done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif
    unique case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (start) begin
          state_n = START;
          sh_n    = {3'b000, sum};
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_n   = ^sum;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          cnt_n   = '0;
          tx_n    = sh[0];
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          sh_n  = sh >> 1;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            idx_n = idx + 3'd1;
            tx_n  = sh[1];
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          cnt_n   = '0;
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          // busy drops and done rises on the same edge
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sum_uart_tx.sv
// Scoreboard bench for sum_uart_tx: random starts, operand churn,
// back-to-back frames and mid-frame reset against a frame-level model.
module tb_sum_uart_tx;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * C;

  typedef struct {
    logic [7:0] b;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] q_a = '0;
  logic [3:0] q_b = '0;
  logic       tx, busy, done;

  int   vectors = 0;
  int   errors = 0;
  int   cyc = 0;
  int   free_at = 0;
  exp_t sb[$];

  bit   active = 1'b0;
  int   pos = 0;
  logic ebits[0:10];

  sum_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .q_a    (q_a),
    .q_b    (q_b),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(string n, logic a, logic e);
    vectors++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic chk_int(string n, int a, int e);
    vectors++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // Reference: one accepted request per idle window, byte = a+b
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!reset_n) begin
      free_at = 0;
    end else if (start && cyc >= free_at) begin
      e.b   = 8'(int'(q_a) + int'(q_b));
      e.acc = cyc;
      sb.push_back(e);
      free_at = cyc + FRAME + 1;
    end
  end

  // Monitor: opens a frame on the falling start bit, checks every cycle
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!reset_n) begin
      active = 1'b0;
      sb.delete();
    end else begin
      if (!active && tx === 1'b0) begin
        if (sb.size() == 0) begin
          errors++;
          vectors++;
          $display("FAIL spurious_frame: tx low with nothing expected (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk_int("start_latency", cyc, e.acc);
          ebits[0] = 1'b0;
          for (int i = 0; i < 8; i++) ebits[i+1] = e.b[i];
          ebits[9] = (NBITS == 11) ? ^e.b : 1'b1;
          ebits[10] = 1'b1;
          active = 1'b1;
          pos = 0;
        end
      end
      if (active) begin
        if (pos < FRAME) begin
          chk("tx_bit", tx, ebits[pos / C]);
          chk("busy_frame", busy, 1'b1);
          chk("done_in_frame", done, 1'b0);
          pos++;
        end else begin
          chk("done_pulse", done, 1'b1);
          chk("busy_at_done", busy, 1'b0);
          chk("tx_at_done", tx, 1'b1);
          active = 1'b0;
        end
      end else begin
        chk("tx_idle", tx, 1'b1);
        chk("busy_idle", busy, 1'b0);
        chk("done_idle", done, 1'b0);
      end
    end
  end

  task automatic pulse(logic [3:0] a, logic [3:0] b);
    @(negedge clk);
    q_a   = a;
    q_b   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    @(negedge clk);
    #2;
    while ((active || sb.size() != 0) && guard < 2000) begin
      @(negedge clk);
      #2;
      guard++;
    end
    vectors++;
    if (guard >= 2000) begin
      errors++;
      $display("FAIL drain_timeout: %0d frames pending, active=%0d", sb.size(), active);
      sb.delete();
      active = 1'b0;
    end
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1;
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);

    pulse(4'd5, 4'd3);
    drain();
    pulse(4'hF, 4'hF);
    drain();

    pulse(4'd1, 4'd1);
    repeat (10) @(negedge clk);
    pulse(4'd9, 4'd7);
    q_a = 4'd9;
    drain();

    @(negedge clk);
    q_a   = 4'd2;
    q_b   = 4'd4;
    start = 1'b1;
    repeat (3 * (FRAME + 1)) @(negedge clk);
    start = 1'b0;
    drain();

    pulse(4'd6, 4'd9);
    repeat (18) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset_tx", tx, 1'b1);
    chk("midreset_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pulse(4'd7, 4'd9);
    drain();

    for (int it = 0; it < 40; it++) begin
      int gap = $urandom_range(0, 8);
      int hold = $urandom_range(1, 2 * FRAME);
      repeat (gap) begin
        @(negedge clk);
        q_a = 4'($urandom);
        q_b = 4'($urandom);
      end
      @(negedge clk);
      start = 1'b1;
      q_a = 4'($urandom);
      q_b = 4'($urandom);
      repeat (($urandom_range(0, 3) == 0) ? hold : 1) begin
        @(negedge clk);
        q_a = 4'($urandom);
        q_b = 4'($urandom);
      end
      start = 1'b0;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
